// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory-port arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Bits needed to hold values 0..max_count (at least one).
  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    while ((1 << w) <= max_count) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side (ibus, dbus) and slave-side signals of the shared memory port.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic                  i_err;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [SEL_WIDTH-1:0]  d_sel;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic                  d_err;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [SEL_WIDTH-1:0]  m_sel;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_ack;

  logic                  stallreq_if;
  logic                  stallreq_mem;

  // Arbiter view: serves the pipeline masters, drives the memory slave.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           m_req, m_we, m_sel, m_addr, m_wdata, stallreq_if, stallreq_mem
  );

  // Environment view: pipeline masters plus the memory slave.
  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, m_rdata, m_ack,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           m_req, m_we, m_sel, m_addr, m_wdata, stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
// Counts cycles of an outstanding slave access; flags the cycle whose increment reaches TIMEOUT.
module bus_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_never
      assign o_expired = 1'b0;
    end else begin : g_tc
      assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between ibus (fetch) and dbus (load/store).
//   ST_IDLE | sample requests, latch winner's command
//   ST_BUSY | m_req held until m_ack or timeout
//   ST_RESP | one-cycle ack/err pulse to the granted master
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  arb_state_e            r_state, w_state_nxt;
  grant_e                r_grant, w_grant_nxt;
  grant_e                r_last_grant, w_last_grant_nxt;
  logic                  r_m_req, w_m_req_nxt;
  logic                  r_m_we, w_m_we_nxt;
  logic [SEL_WIDTH-1:0]  r_m_sel, w_m_sel_nxt;
  logic [ADDR_WIDTH-1:0] r_m_addr, w_m_addr_nxt;
  logic [DATA_WIDTH-1:0] r_m_wdata, w_m_wdata_nxt;
  logic                  r_i_ack, w_i_ack_nxt;
  logic                  r_i_err, w_i_err_nxt;
  logic [DATA_WIDTH-1:0] r_i_rdata, w_i_rdata_nxt;
  logic                  r_d_ack, w_d_ack_nxt;
  logic                  r_d_err, w_d_err_nxt;
  logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata_nxt;
  logic                  w_cnt_clear, w_cnt_en, w_expired;
  logic                  w_pick_d;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_expired(w_expired)
  );

  // dbus wins ties unless it was the last master to complete an access.
  assign w_pick_d = bus.d_req && !(bus.i_req && (r_last_grant == GRANT_D));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_I;
      r_last_grant <= GRANT_I;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_sel      <= '0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_m_req      <= w_m_req_nxt;
      r_m_we       <= w_m_we_nxt;
      r_m_sel      <= w_m_sel_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_i_ack      <= w_i_ack_nxt;
      r_i_err      <= w_i_err_nxt;
      r_i_rdata    <= w_i_rdata_nxt;
      r_d_ack      <= w_d_ack_nxt;
      r_d_err      <= w_d_err_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_m_req_nxt      = r_m_req;
    w_m_we_nxt       = r_m_we;
    w_m_sel_nxt      = r_m_sel;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_i_ack_nxt      = 1'b0;
    w_i_err_nxt      = 1'b0;
    w_i_rdata_nxt    = '0;
    w_d_ack_nxt      = 1'b0;
    w_d_err_nxt      = 1'b0;
    w_d_rdata_nxt    = '0;
    w_cnt_clear      = 1'b0;
    w_cnt_en         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cnt_clear = 1'b1;
        if (bus.i_req || bus.d_req) begin
          w_state_nxt = ST_BUSY;
          w_m_req_nxt = 1'b1;
          if (w_pick_d) begin
            w_grant_nxt   = GRANT_D;
            w_m_we_nxt    = bus.d_we;
            w_m_sel_nxt   = bus.d_sel;
            w_m_addr_nxt  = bus.d_addr;
            w_m_wdata_nxt = bus.d_wdata;
          end else begin
            w_grant_nxt   = GRANT_I;
            w_m_we_nxt    = 1'b0;
            w_m_sel_nxt   = '1;
            w_m_addr_nxt  = bus.i_addr;
            w_m_wdata_nxt = '0;
          end
        end
      end
      ST_BUSY: begin
        w_cnt_en = !bus.m_ack;
        if (bus.m_ack) begin
          w_state_nxt      = ST_RESP;
          w_m_req_nxt      = 1'b0;
          w_last_grant_nxt = r_grant;
          if (r_grant == GRANT_D) begin
            w_d_ack_nxt   = 1'b1;
            w_d_rdata_nxt = bus.m_rdata;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = bus.m_rdata;
          end
        end else if (w_expired) begin
          // Abort: rdata stays 0 and the round-robin history is left untouched.
          w_state_nxt = ST_RESP;
          w_m_req_nxt = 1'b0;
          if (r_grant == GRANT_D) w_d_err_nxt = 1'b1;
          else                    w_i_err_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_m_req_nxt = 1'b0;
      end
    endcase
  end

  assign bus.m_req        = r_m_req;
  assign bus.m_we         = r_m_we;
  assign bus.m_sel        = r_m_sel;
  assign bus.m_addr       = r_m_addr;
  assign bus.m_wdata      = r_m_wdata;
  assign bus.i_ack        = r_i_ack;
  assign bus.i_err        = r_i_err;
  assign bus.i_rdata      = r_i_rdata;
  assign bus.d_ack        = r_d_ack;
  assign bus.d_err        = r_d_err;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.stallreq_if  = bus.i_req & ~(r_i_ack | r_i_err);
  assign bus.stallreq_mem = bus.d_req & ~(r_d_ack | r_d_err);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of what the masters have outstanding and who completed last.
  bit          p_i, p_d, last_was_d;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic        p_dwe;
  logic [3:0]  p_dsel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.i_req   = p_i;
    bus.i_addr  = p_iaddr;
    bus.d_req   = p_d;
    bus.d_we    = p_dwe;
    bus.d_sel   = p_dsel;
    bus.d_addr  = p_daddr;
    bus.d_wdata = p_dwdata;
  endtask

  task automatic new_i(input logic [31:0] addr);
    p_i = 1'b1; p_iaddr = addr;
    drive();
  endtask

  task automatic new_d(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    p_d = 1'b1; p_dwe = we; p_dsel = sel; p_daddr = addr; p_dwdata = wdata;
    drive();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_req"}, bus.m_req, 1'b0);
    check({tag, "_acks"}, {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 4'b0000);
    check({tag, "_rdata"}, {bus.i_rdata, bus.d_rdata}, 64'd0);
  endtask

  task automatic reset_dut(input int cycles);
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      check_quiet("rst");
      check("rst_stall_if", bus.stallreq_if, p_i);
    end
    rst = 1'b1;
    last_was_d = 1'b0;
  endtask

  // Call in an IDLE cycle with the requests already driven; returns in the next IDLE cycle.
  // delay >= TO means the slave never answers.
  task automatic run_access(input int delay, input logic [31:0] rd, input bit reissue);
    bit          win_d;
    logic [31:0] ea, ewd, erd;
    logic        ewe, eack, eerr;
    logic [3:0]  esel;
    int          highs;
    win_d = p_d && !(p_i && last_was_d);
    if (win_d) begin
      ea = p_daddr; ewe = p_dwe; esel = p_dsel; ewd = p_dwdata;
    end else begin
      ea = p_iaddr; ewe = 1'b0; esel = 4'hF; ewd = 32'd0;
    end
    tick();
    check("cmd_m_req", bus.m_req, 1'b1);
    check("cmd_addr", bus.m_addr, ea);
    check("cmd_we", bus.m_we, ewe);
    check("cmd_sel", bus.m_sel, esel);
    check("cmd_wdata", bus.m_wdata, ewd);
    check("busy_stall", {bus.stallreq_if, bus.stallreq_mem}, {p_i, p_d});
    highs = 1;
    if (delay < TO) begin
      for (int k = 0; k < delay; k++) begin
        tick();
        check("hold_m_req", bus.m_req, 1'b1);
        check("hold_addr", bus.m_addr, ea);
      end
      bus.m_ack = 1'b1; bus.m_rdata = rd;
      tick();
      bus.m_ack = 1'b0; bus.m_rdata = $urandom;
      eack = 1'b1; eerr = 1'b0; erd = rd;
      last_was_d = win_d;
    end else begin
      for (int k = 0; k < 40; k++) begin
        tick();
        if (bus.m_req !== 1'b1) break;
        highs++;
      end
      check("timeout_len", highs, TO);
      eack = 1'b0; eerr = 1'b1; erd = 32'd0;
    end
    check("resp_m_req", bus.m_req, 1'b0);
    check("resp_i", {bus.i_ack, bus.i_err, bus.i_rdata},
          win_d ? 34'd0 : {eack, eerr, erd});
    check("resp_d", {bus.d_ack, bus.d_err, bus.d_rdata},
          win_d ? {eack, eerr, erd} : 34'd0);
    check("resp_stall", {bus.stallreq_if, bus.stallreq_mem},
          {p_i && win_d, p_d && !win_d});
    if (win_d) begin
      if (reissue) new_d($urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
      else p_d = 1'b0;
    end else begin
      if (reissue) new_i($urandom);
      else p_i = 1'b0;
    end
    drive();
    tick();
    check_quiet("idle");
  endtask

  initial begin
    p_i = 0; p_d = 0; last_was_d = 0;
    p_iaddr = 0; p_daddr = 0; p_dwdata = 0; p_dwe = 0; p_dsel = 0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    drive();

    // Reset held with a fetch pending, then a single fetch acked immediately.
    new_i(32'h0000_0010);
    reset_dut(3);
    run_access(0, 32'h3401_1100, 1'b0);

    // Contention after reset: store first, then alternate while both stay pending.
    reset_dut(1);
    new_d(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    new_i(32'h0000_0200);
    run_access(1, 32'h1111_1111, 1'b1);
    run_access(2, 32'h2222_2222, 1'b1);
    run_access(0, 32'h3333_3333, 1'b1);
    run_access(3, 32'h4444_4444, 1'b0);
    run_access(0, 32'h5555_5555, 1'b0);

    // Timeout on a load, then a pending fetch is served normally.
    reset_dut(1);
    new_d(1'b0, 4'hF, 32'h0000_0400, 32'h0);
    new_i(32'h0000_0020);
    run_access(TO, 32'h0, 1'b0);
    run_access(2, 32'hCAFE_F00D, 1'b0);

    // Reset during a dbus access, then a late m_ack.
    new_d(1'b0, 4'h3, 32'h0000_0800, 32'h0);
    tick();
    check("mid_m_req", bus.m_req, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check_quiet("mid_rst");
    p_d = 1'b0; drive();
    rst = 1'b1; last_was_d = 1'b0;
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    tick();
    bus.m_ack = 1'b0;
    check_quiet("late_ack");
    tick();
    check_quiet("late_ack2");

    // Stray ack in IDLE, then a normal fetch shows the state stayed IDLE.
    bus.m_ack = 1'b1; bus.m_rdata = 32'h5A5A_5A5A;
    tick();
    bus.m_ack = 1'b0;
    check_quiet("stray");
    new_i(32'h0000_0030);
    run_access(1, 32'h0BAD_CAFE, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int dly;
      if (!p_i && $urandom_range(0, 1) == 1) new_i($urandom);
      if (!p_d && ($urandom_range(0, 1) == 1 || !p_i))
        new_d($urandom_range(0, 1), 4'($urandom), $urandom, $urandom);
      dly = ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(0, 4));
      run_access(dly, $urandom, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory port of the minimal SOPC between the instruction-fetch master (ibus, read-only) and the MEM-stage data master (dbus, read/write). Each access is forwarded to the slave with registered outputs, and the response is returned to the owning master. The block also raises stall requests to the pipeline stall controller while a master waits. A per-access timeout prevents the pipeline from hanging on an unresponsive slave.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-select width is DATA_WIDTH/8
TIMEOUT, 255, maximum cycles m_req is held without m_ack before aborting; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (rst=0 resets on the rising clk edge)
i_req  in  1  fetch request; held with i_addr until i_ack or i_err
i_addr  in  ADDR_WIDTH  fetch address
i_ack  out  1  one-cycle completion pulse
i_err  out  1  one-cycle timeout pulse
i_rdata  out  DATA_WIDTH  fetch data; valid with i_ack
d_req  in  1  data request; held with its payload until d_ack or d_err
d_we  in  1  1 = store
d_sel  in  DATA_WIDTH/8  byte enables
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_ack  out  1  completion pulse
d_err  out  1  timeout pulse
d_rdata  out  DATA_WIDTH  load data; valid with d_ack
m_req  out  1  slave request; level, held until m_ack or timeout
m_we, m_sel, m_addr, m_wdata  out  as dbus  slave command (ibus: we=0, sel=all ones, wdata=0)
m_rdata  in  DATA_WIDTH  slave read data
m_ack  in  1  slave completion pulse
stallreq_if  out  1  i_req & ~(i_ack|i_err), combinational
stallreq_mem  out  1  d_req & ~(d_ack|d_err), combinational

Behaviour:
- States: IDLE, BUSY, RESP. Registers: grant (I/D), last_grant, timeout counter.
- Reset (rst=0): state IDLE; m_req, m_*, all ack/err/rdata outputs 0; counter 0; last_grant=I, so dbus wins the first tie. Reset takes effect mid-transaction: the slave access is abandoned and no ack is issued.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only d_req → grant D. Only i_req → grant I.
  - Both requesting → grant D, unless last_grant=D, then grant I (round-robin).
  - On grant: latch the command into m_*, m_req=1 next cycle, go to BUSY, counter cleared.
  - No request → stay in IDLE.
- BUSY:
  - m_req held and the command is stable.
  - m_ack=1 → m_req=0, capture m_rdata, go to RESP, last_grant=grant.
  - Else counter+1. If TIMEOUT≠0 and the counter reaches TIMEOUT (m_req high exactly TIMEOUT cycles) → m_req=0, rdata=0, go to RESP with the error flag set.
- RESP (one cycle):
  - The granted master's ack (or err) = 1 and its rdata is valid. The other master's outputs are 0.
  - No new grant this cycle. Next state is IDLE.
- Latency: request seen at cycle 0 → m_req at cycle 1; slave ack at cycle k → master ack at k+1. Minimum access occupancy is 3 cycles.
- m_ack outside BUSY is ignored.
- i_rdata/d_rdata return to 0 when not in RESP.
- Masters must not drop req before ack/err. Behaviour on early deassertion is undefined.
- err and ack are never asserted together.

Decomposition:
- Shared package: state encodings (ST_IDLE/ST_BUSY/ST_RESP), master IDs (GRANT_I/GRANT_D), bus width constants, counter-width function.
- One sub-module: bus_timeout_cnt (clear/enable inputs, expired output, TIMEOUT parameter, 0 = never expires).

Test Plan:
1. Reset: hold rst=0 for 3 cycles with i_req=1 → m_req=0, i_ack=0, stallreq_if=1. After release, i_req sampled, m_req=1 one cycle later with m_addr=i_addr.
2. Single fetch: i_addr=0x00000010, slave acks the cycle m_req is first seen with m_rdata=0x34011100 → i_ack one cycle later, i_rdata=0x34011100, m_we=0, m_sel=0xF, stallreq_if=0 in that cycle.
3. Contention: i_req and d_req rise together after reset (store 0xDEADBEEF to 0x100, sel 0xF) → dbus served first with m_we=1, m_wdata=0xDEADBEEF. Then ibus is served. With both still pending, grants alternate D, I, D.
4. Timeout: TIMEOUT=8, slave never acks a load → m_req high exactly 8 cycles, then d_err one-cycle pulse, d_ack=0, d_rdata=0. The arbiter returns to IDLE and serves a pending i_req normally.
5. Reset mid-access: rst=0 during BUSY (dbus) → m_req=0 next edge, no d_ack/d_err. A late m_ack after release is ignored.
6. Stray ack: pulse m_ack in IDLE with no requests → no ack/err on either master, state stays IDLE.
